// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: parallel words in over valid/ready, MSB-first serial out,
// optional even/odd parity bit appended to each frame.
module parity_frame_tx #(
    parameter int unsigned DATA_W    = 3,
    parameter bit          PARITY_EN = 1'b1,
    parameter bit          ODD       = 1'b0
) (
    input  logic              C,
    input  logic              NR,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VLD,
    output logic              DIN_RDY,
    output logic              SOUT,
    output logic              SOUT_VLD,
    output logic              FRAME,
    output logic              BUSY
);

    localparam int unsigned FrameLen = DATA_W + 32'(PARITY_EN);
    localparam int unsigned CntW     = $clog2(FrameLen);
    localparam logic [CntW-1:0] LastData = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_full_q;
    logic                par_q;
    logic [CntW-1:0]     cnt_q;
    logic                sout_q;
    logic                sout_vld_q;
    logic                frame_q;

    logic                accept;
    logic                last_bit;
    logic                load_now;
    logic [DATA_W-1:0]   load_word;

    always_comb begin
        accept    = DIN_VLD & ~hold_full_q;
        last_bit  = (state_q == StPar) |
                    ((state_q == StData) & (cnt_q == LastData) & ~PARITY_EN);
        // A held word always takes priority over DIN when a new frame starts.
        load_word = hold_full_q ? hold_q : DIN;
        load_now  = ((state_q == StIdle) & accept) | (last_bit & (hold_full_q | accept));
    end

    always_ff @(posedge C or negedge NR) begin
        if (!NR) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            sout_q      <= 1'b0;
            sout_vld_q  <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (load_now) begin
                // First bit goes straight to SOUT; shifter keeps the remaining bits.
                state_q    <= StData;
                sout_q     <= load_word[DATA_W-1];
                shift_q    <= load_word << 1;
                par_q      <= (^load_word) ^ ODD;
                cnt_q      <= '0;
                sout_vld_q <= 1'b1;
                frame_q    <= 1'b1;
            end else if (last_bit) begin
                state_q    <= StIdle;
                sout_q     <= 1'b0;
                sout_vld_q <= 1'b0;
                cnt_q      <= '0;
            end else if (state_q == StData) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LastData) begin
                    state_q <= StPar;
                    sout_q  <= par_q;
                end else begin
                    sout_q  <= shift_q[DATA_W-1];
                    shift_q <= shift_q << 1;
                end
            end

            if (hold_full_q && load_now) begin
                hold_full_q <= 1'b0;
            end else if (accept && !load_now) begin
                hold_q      <= DIN;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign DIN_RDY  = ~hold_full_q;
    assign SOUT     = sout_q;
    assign SOUT_VLD = sout_vld_q;
    assign FRAME    = frame_q;
    assign BUSY     = (state_q != StIdle) | hold_full_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: three parameterisations (default, odd parity,
// no parity) driven with directed vectors, back-to-back, backpressure, reset and loopback.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       nr;
    logic [2:0] din [3];
    logic [2:0] vld;
    logic [2:0] rdy, sout, sov, frm, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parity_frame_tx u_def (
        .C(clk), .NR(nr), .DIN(din[0]), .DIN_VLD(vld[0]), .DIN_RDY(rdy[0]),
        .SOUT(sout[0]), .SOUT_VLD(sov[0]), .FRAME(frm[0]), .BUSY(busy[0])
    );
    parity_frame_tx #(.ODD(1'b1)) u_odd (
        .C(clk), .NR(nr), .DIN(din[1]), .DIN_VLD(vld[1]), .DIN_RDY(rdy[1]),
        .SOUT(sout[1]), .SOUT_VLD(sov[1]), .FRAME(frm[1]), .BUSY(busy[1])
    );
    parity_frame_tx #(.PARITY_EN(1'b0)) u_np (
        .C(clk), .NR(nr), .DIN(din[2]), .DIN_VLD(vld[2]), .DIN_RDY(rdy[2]),
        .SOUT(sout[2]), .SOUT_VLD(sov[2]), .FRAME(frm[2]), .BUSY(busy[2])
    );

    typedef struct {
        int         sel;
        logic [2:0] word;
        logic [3:0] bits;   // expected serial bits, first bit in [3]
        int         len;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Leaves time at #1 after the accept edge, when the first frame bit is visible.
    task automatic send_one(input int s, input logic [2:0] w);
        check($sformatf("rdy before send dut%0d", s), 32'(rdy[s]), 32'd1);
        din[s] = w;
        vld[s] = 1'b1;
        @(posedge clk); #1;
        vld[s] = 1'b0;
    endtask

    task automatic check_frame(input int s, input logic [3:0] bits, input int len,
                               input string nm);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s sout[%0d]", nm, i), 32'(sout[s]), 32'(bits[3-i]));
            check($sformatf("%s vld[%0d]", nm, i), 32'(sov[s]), 32'd1);
            check($sformatf("%s frame[%0d]", nm, i), 32'(frm[s]), 32'(i == 0));
            @(posedge clk); #1;
        end
        check($sformatf("%s idle vld", nm), 32'(sov[s]), 32'd0);
        check($sformatf("%s idle sout", nm), 32'(sout[s]), 32'd0);
        check($sformatf("%s idle busy", nm), 32'(busy[s]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s2;
        logic [2:0]  words [3];
        logic [11:0] stream;
        logic        acc, prev_sov;
        int          k, nbits, nfr, rises, saw_low;
        logic [2:0]  sentq [$];
        logic [2:0]  rxw, exp_w;
        int          nsent, bi, nfr6;

        vecs[0] = '{0, 3'b101, 4'b1010, 4};
        vecs[1] = '{0, 3'b011, 4'b0110, 4};
        vecs[2] = '{0, 3'b000, 4'b0000, 4};
        vecs[3] = '{0, 3'b110, 4'b1100, 4};
        vecs[4] = '{1, 3'b000, 4'b0001, 4};
        vecs[5] = '{1, 3'b101, 4'b1011, 4};
        vecs[6] = '{1, 3'b111, 4'b1110, 4};
        vecs[7] = '{2, 3'b110, 4'b1100, 3};
        vecs[8] = '{2, 3'b011, 4'b0110, 3};

        nr  = 1'b0;
        vld = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;

        #12;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset sout dut%0d", s), 32'(sout[s]), 32'd0);
            check($sformatf("reset vld dut%0d", s), 32'(sov[s]), 32'd0);
            check($sformatf("reset frame dut%0d", s), 32'(frm[s]), 32'd0);
            check($sformatf("reset busy dut%0d", s), 32'(busy[s]), 32'd0);
            check($sformatf("reset rdy dut%0d", s), 32'(rdy[s]), 32'd1);
        end
        @(negedge clk) nr = 1'b1;
        @(posedge clk); #1;

        // Single frames on each parameterisation
        foreach (vecs[v]) begin
            send_one(vecs[v].sel, vecs[v].word);
            check_frame(vecs[v].sel, vecs[v].bits, vecs[v].len, $sformatf("vec%0d", v));
            @(posedge clk); #1;
        end

        // Back-to-back 011 then 111: second word sits in hold
        s2 = 8'b0110_1111;
        din[0] = 3'b011;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) din[0] = 3'b111;
            if (i == 1) vld[0] = 1'b0;
            check($sformatf("b2b sout[%0d]", i), 32'(sout[0]), 32'(s2[7-i]));
            check($sformatf("b2b vld[%0d]", i), 32'(sov[0]), 32'd1);
            check($sformatf("b2b frame[%0d]", i), 32'(frm[0]), 32'(i == 0 || i == 4));
            if (i == 1) check("b2b rdy while hold full", 32'(rdy[0]), 32'd0);
            if (i == 4) check("b2b rdy after drain", 32'(rdy[0]), 32'd1);
            @(posedge clk); #1;
        end
        check("b2b end vld", 32'(sov[0]), 32'd0);
        check("b2b end busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;

        // Backpressure: DIN_VLD held high across three words
        words[0] = 3'b101; words[1] = 3'b010; words[2] = 3'b110;
        stream = '0; k = 0; nbits = 0; nfr = 0; rises = 0; saw_low = 0; prev_sov = 1'b0;
        din[0] = words[0];
        vld[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            acc = vld[0] & rdy[0];
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 3) din[0] = words[k];
                else vld[0] = 1'b0;
            end
            if (!rdy[0]) saw_low = 1;
            if (sov[0]) begin
                if (nbits < 12) stream[11-nbits] = sout[0];
                nbits++;
                if (frm[0]) nfr++;
                if (!prev_sov) rises++;
            end
            prev_sov = sov[0];
        end
        vld[0] = 1'b0;
        check("bp words accepted", 32'(k), 32'd3);
        check("bp stream", 32'(stream), 32'hA5C);
        check("bp bit count", 32'(nbits), 32'd12);
        check("bp frame count", 32'(nfr), 32'd3);
        check("bp contiguous vld", 32'(rises), 32'd1);
        check("bp rdy went low", 32'(saw_low), 32'd1);

        // Asynchronous reset mid-frame, then a clean frame
        send_one(0, 3'b110);
        @(posedge clk); #1;
        check("rst pre bit1", 32'(sout[0]), 32'd1);
        #2 nr = 1'b0;
        #1;
        check("rst async sout", 32'(sout[0]), 32'd0);
        check("rst async vld", 32'(sov[0]), 32'd0);
        check("rst async frame", 32'(frm[0]), 32'd0);
        check("rst async busy", 32'(busy[0]), 32'd0);
        check("rst async rdy", 32'(rdy[0]), 32'd1);
        @(negedge clk) nr = 1'b1;
        @(posedge clk); #1;
        check("rst stays idle", 32'(sov[0]), 32'd0);
        send_one(0, 3'b110);
        check_frame(0, 4'b1100, 4, "post-rst");

        // Loopback into a 3-bit shift receiver with random words
        nsent = 0; bi = 0; nfr6 = 0; rxw = '0;
        din[0] = 3'($urandom);
        vld[0] = 1'b1;
        for (int c = 0; c < 4500 && !(nsent == 1000 && nfr6 == 1000); c++) begin
            acc = vld[0] & rdy[0];
            @(posedge clk); #1;
            if (acc) begin
                sentq.push_back(din[0]);
                nsent++;
                if (nsent < 1000) din[0] = 3'($urandom);
                else vld[0] = 1'b0;
            end
            if (sov[0]) begin
                if (frm[0]) bi = 0;
                if (bi < 3) begin
                    rxw = {rxw[1:0], sout[0]};
                end else if (sentq.size() == 0) begin
                    check("loop unexpected frame", 32'd1, 32'd0);
                end else begin
                    exp_w = sentq.pop_front();
                    check("loop word", 32'(rxw), 32'(exp_w));
                    check("loop parity", 32'(sout[0]), 32'(^rxw));
                    nfr6++;
                end
                bi++;
            end
        end
        vld[0] = 1'b0;
        check("loop words sent", 32'(nsent), 32'd1000);
        check("loop frames received", 32'(nfr6), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
